// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register latency countdowns, WAW/RAW stall,
// branch-redirect flush sequencing and external-stall freeze for the in-order pipeline.
module hazard_scoreboard #(
  parameter int REG_ADDR_W   = 5,
  parameter int LAT_W        = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dec_valid,
  input  logic [REG_ADDR_W-1:0]      dec_rs1,
  input  logic                       dec_rs1_used,
  input  logic [REG_ADDR_W-1:0]      dec_rs2,
  input  logic                       dec_rs2_used,
  input  logic [REG_ADDR_W-1:0]      dec_rd,
  input  logic                       dec_rd_wr,
  input  logic [LAT_W-1:0]           dec_lat,
  input  logic                       ex_redirect,
  input  logic                       ext_stall,
  output logic                       PC_write,
  output logic                       IFID_write,
  output logic                       Mux_select,
  output logic                       IF_kill,
  output logic                       DEC_kill,
  output logic [2**REG_ADDR_W-1:0]   busy_vec,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic                       stall_sat
);

  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam int FLUSH_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_RELOAD = FLUSH_W'(FLUSH_CYCLES - 1);

  logic [LAT_W-1:0]   cnt_r [NUM_REGS];
  logic [FLUSH_W-1:0] flush_cnt_r;
  logic [CNT_W-1:0]   stall_cnt_r;

  logic hazard_s;
  logic flushing_s;
  logic issue_s;
  logic load_s;

  // Busy view of the scoreboard; x0 is hardwired and never reported busy.
  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      busy_vec[i] = (cnt_r[i] != '0);
    end
  end

  // Hazard, flush and issue qualification, all from registered state.
  always_comb begin
    hazard_s   = dec_valid &&
                 ((dec_rs1_used && (dec_rs1 != '0) && busy_vec[dec_rs1]) ||
                  (dec_rs2_used && (dec_rs2 != '0) && busy_vec[dec_rs2]) ||
                  (dec_rd_wr    && (dec_rd  != '0) && busy_vec[dec_rd]));
    flushing_s = ex_redirect || (flush_cnt_r != '0);
    issue_s    = dec_valid && !hazard_s && !flushing_s && !ext_stall && !rst;
    load_s     = issue_s && dec_rd_wr && (dec_rd != '0) && (dec_lat != '0);
  end

  // Pipeline control outputs in priority order: reset, freeze, flush, stall, run.
  always_comb begin
    PC_write   = 1'b1;
    IFID_write = 1'b1;
    Mux_select = 1'b0;
    IF_kill    = 1'b0;
    DEC_kill   = 1'b0;
    if (rst) begin
      PC_write   = 1'b0;
      IFID_write = 1'b0;
      Mux_select = 1'b1;
      IF_kill    = 1'b1;
      DEC_kill   = 1'b1;
    end else if (ext_stall) begin
      PC_write   = 1'b0;
      IFID_write = 1'b0;
    end else if (flushing_s) begin
      Mux_select = 1'b1;
      IF_kill    = 1'b1;
      DEC_kill   = 1'b1;
    end else if (hazard_s) begin
      PC_write   = 1'b0;
      IFID_write = 1'b0;
      Mux_select = 1'b1;
    end else begin
      PC_write   = 1'b1;
    end
  end

  // Scoreboard countdowns, flush sequencer and stall counter; all frozen by ext_stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_r[i] <= '0;
      end
      flush_cnt_r <= '0;
      stall_cnt_r <= '0;
    end else if (!ext_stall) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (cnt_r[i] != '0) begin
          cnt_r[i] <= cnt_r[i] - LAT_W'(1);
        end
      end
      // A fresh issue overrides the decrement of the same entry.
      if (load_s) begin
        cnt_r[dec_rd] <= dec_lat;
      end

      if (ex_redirect) begin
        flush_cnt_r <= FLUSH_RELOAD;
      end else if (flush_cnt_r != '0) begin
        flush_cnt_r <= flush_cnt_r - FLUSH_W'(1);
      end

      if (issue_s || flushing_s) begin
        stall_cnt_r <= '0;
      end else if (hazard_s && (stall_cnt_r != '1)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign stall_sat = &stall_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic,
// compared each cycle against an integer "remaining cycles per register" model.
module tb_hazard_scoreboard;

  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dec_valid = 1'b0;
  logic [4:0]  dec_rs1 = 5'd0;
  logic        dec_rs1_used = 1'b0;
  logic [4:0]  dec_rs2 = 5'd0;
  logic        dec_rs2_used = 1'b0;
  logic [4:0]  dec_rd = 5'd0;
  logic        dec_rd_wr = 1'b0;
  logic [2:0]  dec_lat = 3'd0;
  logic        ex_redirect = 1'b0;
  logic        ext_stall = 1'b0;

  logic        pc_w, ifid_w, mux_s, if_k, dec_k, sat4;
  logic [31:0] busy4;
  logic [3:0]  scnt4;
  logic        pc_w2, ifid_w2, mux_s2, if_k2, dec_k2, sat2;
  logic [31:0] busy2;
  logic [1:0]  scnt2;

  int checks = 0;
  int errors = 0;

  int rem [32];
  int flush_left;
  int sc4;
  int sc2;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_ADDR_W(5), .LAT_W(3), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs1_used(dec_rs1_used),
    .dec_rs2(dec_rs2), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_rd_wr(dec_rd_wr), .dec_lat(dec_lat),
    .ex_redirect(ex_redirect), .ext_stall(ext_stall),
    .PC_write(pc_w), .IFID_write(ifid_w), .Mux_select(mux_s),
    .IF_kill(if_k), .DEC_kill(dec_k),
    .busy_vec(busy4), .stall_cnt(scnt4), .stall_sat(sat4)
  );

  hazard_scoreboard #(.REG_ADDR_W(5), .LAT_W(3), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs1_used(dec_rs1_used),
    .dec_rs2(dec_rs2), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_rd_wr(dec_rd_wr), .dec_lat(dec_lat),
    .ex_redirect(ex_redirect), .ext_stall(ext_stall),
    .PC_write(pc_w2), .IFID_write(ifid_w2), .Mux_select(mux_s2),
    .IF_kill(if_k2), .DEC_kill(dec_k2),
    .busy_vec(busy2), .stall_cnt(scnt2), .stall_sat(sat2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // One pipeline cycle: drive inputs, check outputs against the model, advance the model.
  task automatic op(input bit rs, input bit v, input int rs1, input bit u1,
                    input int rs2, input bit u2, input int rd, input bit wr,
                    input int lat, input bit redir, input bit ext);
    bit          hz, fl, iss;
    logic [31:0] busy;
    logic [4:0]  exp_ctrl;
    @(negedge clk);
    rst = rs; dec_valid = v;
    dec_rs1 = 5'(rs1); dec_rs1_used = u1;
    dec_rs2 = 5'(rs2); dec_rs2_used = u2;
    dec_rd = 5'(rd); dec_rd_wr = wr; dec_lat = 3'(lat);
    ex_redirect = redir; ext_stall = ext;
    #1;
    busy = 32'd0;
    for (int i = 1; i < 32; i++) busy[i] = (rem[i] > 0);
    hz  = v && ((u1 && rs1 != 0 && rem[rs1] > 0) ||
                (u2 && rs2 != 0 && rem[rs2] > 0) ||
                (wr && rd  != 0 && rem[rd]  > 0));
    fl  = redir || (flush_left > 0);
    iss = v && !hz && !fl && !ext && !rs;
    if (rs)       exp_ctrl = 5'b00111;
    else if (ext) exp_ctrl = 5'b00000;
    else if (fl)  exp_ctrl = 5'b11111;
    else if (hz)  exp_ctrl = 5'b00100;
    else          exp_ctrl = 5'b11000;
    check("ctrl",      {27'd0, pc_w, ifid_w, mux_s, if_k, dec_k}, {27'd0, exp_ctrl});
    check("ctrl_w2",   {27'd0, pc_w2, ifid_w2, mux_s2, if_k2, dec_k2}, {27'd0, exp_ctrl});
    check("busy_vec",  busy4, busy);
    check("busy_w2",   busy2, busy);
    check("stall_cnt", {28'd0, scnt4}, 32'(sc4));
    check("stall_sat", {31'd0, sat4}, {31'd0, (sc4 == 15)});
    check("stall_cnt_w2", {30'd0, scnt2}, 32'(sc2));
    check("stall_sat_w2", {31'd0, sat2}, {31'd0, (sc2 == 3)});
    @(posedge clk);
    if (rs) begin
      foreach (rem[i]) rem[i] = 0;
      flush_left = 0; sc4 = 0; sc2 = 0;
    end else if (!ext) begin
      foreach (rem[i]) if (rem[i] > 0) rem[i]--;
      if (iss && wr && rd != 0 && lat != 0) rem[rd] = lat;
      if (redir) flush_left = FLUSH_CYCLES - 1;
      else if (flush_left > 0) flush_left--;
      if (iss || fl) begin
        sc4 = 0; sc2 = 0;
      end else if (hz) begin
        if (sc4 < 15) sc4++;
        if (sc2 < 3) sc2++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    foreach (rem[i]) rem[i] = 0;
    flush_left = 0; sc4 = 0; sc2 = 0;

    // reset held
    op(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    op(1, 1, 3, 1, 4, 1, 5, 1, 7, 1, 0);
    idle(1);

    // load-use: rd=5 lat=1 then rs1=5
    op(0, 1, 1, 1, 2, 1, 5, 1, 1, 0, 0);
    op(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
    op(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
    idle(2);

    // long latency: rd=7 lat=5, dependent on rs2
    op(0, 1, 1, 1, 2, 1, 7, 1, 5, 0, 0);
    for (int k = 0; k < 7; k++) op(0, 1, 0, 0, 7, 1, 10, 1, 0, 0, 0);
    idle(2);

    // x0 and unused sources
    op(0, 1, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    op(0, 1, 0, 1, 0, 0, 11, 0, 0, 0, 0);
    op(0, 1, 0, 0, 0, 0, 7, 1, 3, 0, 0);
    op(0, 1, 0, 0, 7, 0, 12, 0, 0, 0, 0);
    idle(4);

    // redirect during pending hazard, second redirect extends the flush
    op(0, 1, 0, 0, 0, 0, 8, 1, 6, 0, 0);
    op(0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
    op(0, 1, 8, 1, 0, 0, 0, 0, 0, 1, 0);
    op(0, 1, 8, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) op(0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // external stall freezes a pending rd=9 lat=3
    op(0, 1, 0, 0, 0, 0, 9, 1, 3, 0, 0);
    for (int k = 0; k < 4; k++) op(0, 1, 9, 1, 0, 0, 0, 0, 0, k[0], 1);
    for (int k = 0; k < 5; k++) op(0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0);

    // reset mid-op with pending rd=4 lat=6 and active flush
    op(0, 1, 0, 0, 0, 0, 4, 1, 6, 0, 0);
    op(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    op(1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    op(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // random traffic over a small register window to provoke hazards
    for (int k = 0; k < 3000; k++) begin
      op(($urandom_range(63) == 0), ($urandom_range(3) != 0),
         $urandom_range(7), $urandom_range(1), $urandom_range(7), $urandom_range(1),
         $urandom_range(7), $urandom_range(1),
         ($urandom_range(2) == 0) ? 0 : $urandom_range(7),
         ($urandom_range(11) == 0), ($urandom_range(7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
